data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//   Responder side of the stage-2 data-memory interface: serves addr/write-enable/write-data from the core.
//   Holds on-chip data RAM and a small memory-mapped I/O window.
//   I/O window: free-running cycle counter, one-shot wake timer (pulse releases the core's WAIT state),
//   and a 4-deep TX FIFO feeding an external byte/word sink.
//   Sits between processor stage 2 (requests) and stage 3 (consumes mem_rdata one cycle later).
// PARAMETERS
//   ADDR_SIZE      18        address width, matches core
//   WORD_SIZE      18        data word width, matches core
//   RAM_ADDR_BITS  10        RAM depth = 2**RAM_ADDR_BITS words
//   IO_BASE        18'h3FF00 first address of 256-word I/O window
// PORTS
//   clock            in   1              single clock, rising edge
//   reset_n          in   1              asynchronous, active-low reset
//   mem_addr         in   ADDR_SIZE      request address (valid every cycle)
//   mem_write_enable in   1              1 = write mem_wdata to mem_addr this cycle
//   mem_wdata        in   WORD_SIZE      write data
//   mem_rdata        out  WORD_SIZE      read data for address of previous cycle
//   wake             out  1              one-cycle pulse when timer expires
//   tx_valid         out  1              TX FIFO not empty
//   tx_data          out  WORD_SIZE      FIFO head word
//   tx_ready         in   1              sink accepts head when tx_valid&&tx_ready
// BEHAVIOUR
//   Interface: one clock (clock); reset_n asynchronous, active-low.
//   Reset values: mem_rdata=0, wake=0, tx_valid=0, FIFO empty, cycle counter=0, timer=0, overflow=0.
//   Reset leaves RAM contents unchanged; reset asserted mid-operation discards FIFO contents and any pending timer.
//   Decode: addr>=IO_BASE -> I/O, offset=addr-IO_BASE (8 bits); otherwise RAM.
//   RAM index = addr[RAM_ADDR_BITS-1:0]; higher address bits below IO_BASE alias (wrap).
//   Read latency 1: mem_rdata registered from the address presented in cycle N, valid in N+1, held until the next edge.
//   Write-first: a write in cycle N makes mem_rdata in N+1 equal mem_wdata (RAM or I/O register).
//   I/O map (offset, R/W):
//     0x00 CYCLE_LO   R   low WORD_SIZE bits of 36-bit free-running counter.
//                         Reading it snapshots the high half into CYCLE_HI.
//     0x01 CYCLE_HI   R   snapshot of bits [35:18] taken at last CYCLE_LO read.
//     0x02 TIMER      R/W write loads down-counter; reads return remaining count.
//                         Decrements each cycle while nonzero. Transition 1->0 asserts wake for exactly 1 cycle.
//                         Writing 0 cancels without a pulse. A write on the cycle of expiry wins: reload, no pulse.
//     0x03 TX_DATA    W   push mem_wdata into FIFO; reads return 0.
//     0x04 STATUS     R/W bit0 empty, bit1 full, bit2 overflow (sticky), bits[5:3] count 0..4, others 0.
//                         Writing bit2=1 clears overflow.
//     other offsets: reads 0, writes ignored.
//   Counter wraps 2**36-1 -> 0 silently. Writes to CYCLE_* are ignored.
//   FIFO: depth 4, first-word fall-through; tx_data = head when tx_valid.
//     pop when tx_valid&&tx_ready; push when TX_DATA write and (not full or pop same cycle).
//     Push while full without pop: word dropped, overflow<=1.
//     Push+pop same cycle: count unchanged; on empty FIFO the pushed word appears next cycle (no bypass).
//   STATUS read reflects state before that cycle's push/pop.
// TESTING
//   Write 18'h12345 to addr 5, read addr 5 next cycle -> mem_rdata=18'h12345 one cycle after read addr.
//   Write addr 5 then read addr 5+2**10 -> aliased, returns same word; write then immediate read same addr -> new data.
//   Write TIMER=3 -> wake high exactly 3 cycles after write edge, one cycle wide; write 0 mid-count -> no pulse.
//   Push 5 words, tx_ready=0 -> STATUS=6'b100_110 (count 4, full, overflow); drain with tx_ready=1 -> words 1..4 in order.
//   Full FIFO, push with tx_ready=1 same cycle -> no overflow, count stays 4.
//   Reset_n pulsed low asynchronously mid-count, FIFO 2 deep -> tx_valid=0, wake=0 immediately; RAM word 5 preserved.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder: stage-2 data memory with RAM, cycle counter, wake timer and TX FIFO
module data_memory_responder #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int RAM_ADDR_BITS = 10,
  parameter logic [ADDR_SIZE-1:0] IO_BASE = 18'h3FF00
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [ADDR_SIZE-1:0] mem_addr,
  input  logic                 mem_write_enable,
  input  logic [WORD_SIZE-1:0] mem_wdata,
  output logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 wake,
  output logic                 tx_valid,
  output logic [WORD_SIZE-1:0] tx_data,
  input  logic                 tx_ready
);
  localparam int CW = 2 * WORD_SIZE;
  logic [WORD_SIZE-1:0] ram [2**RAM_ADDR_BITS];
  logic [WORD_SIZE-1:0] fifo [4];
  logic [WORD_SIZE-1:0] rdata_q, rdata_d, timer_q, timer_d, hi_q, hi_d, status, io_rd;
  logic [CW-1:0] cnt_q;
  logic [2:0] count_q, count_d;
  logic [1:0] rp_q, wp_q;
  logic wake_q, wake_d, ovf_q, ovf_d;
  logic is_io, wr_io, full, pop, push_req, push, timer_wr;
  logic [7:0] off;
  assign is_io = mem_addr >= IO_BASE;
  assign off = mem_addr[7:0] - IO_BASE[7:0];
  assign wr_io = mem_write_enable && is_io;
  assign full = count_q == 3'd4;
  assign tx_valid = count_q != 3'd0;
  assign tx_data = fifo[rp_q];
  assign pop = tx_valid && tx_ready;
  assign push_req = wr_io && off == 8'h03;
  assign push = push_req && (!full || pop);
  assign timer_wr = wr_io && off == 8'h02;
  assign status = {{(WORD_SIZE-6){1'b0}}, count_q, ovf_q, full, !tx_valid};
  assign mem_rdata = rdata_q;
  assign wake = wake_q;
  // next state: write-first read data, timer countdown, CYCLE_HI snapshot, FIFO bookkeeping
  always_comb begin
    io_rd = off == 8'h00 ? cnt_q[WORD_SIZE-1:0] : off == 8'h01 ? hi_q : off == 8'h02 ? timer_q : off == 8'h04 ? status : '0;
    rdata_d = mem_write_enable ? mem_wdata : is_io ? io_rd : ram[mem_addr[RAM_ADDR_BITS-1:0]];
    timer_d = timer_wr ? mem_wdata : timer_q != '0 ? timer_q - WORD_SIZE'(1) : timer_q;
    wake_d = !timer_wr && timer_q == WORD_SIZE'(1);
    hi_d = is_io && !mem_write_enable && off == 8'h00 ? cnt_q[CW-1:WORD_SIZE] : hi_q;
    count_d = push && !pop ? count_q + 3'd1 : pop && !push ? count_q - 3'd1 : count_q;
    ovf_d = push_req && !push ? 1'b1 : wr_io && off == 8'h04 && mem_wdata[2] ? 1'b0 : ovf_q;
  end
  // control state; reset drops FIFO contents and any pending timer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      wake_q <= 1'b0;
      timer_q <= '0;
      hi_q <= '0;
      cnt_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      rp_q <= '0;
      wp_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      wake_q <= wake_d;
      timer_q <= timer_d;
      hi_q <= hi_d;
      cnt_q <= cnt_q + CW'(1);
      count_q <= count_d;
      ovf_q <= ovf_d;
      rp_q <= rp_q + 2'(pop);
      wp_q <= wp_q + 2'(push);
    end
  end
  // storage arrays keep their contents across reset
  always_ff @(posedge clock) begin
    if (mem_write_enable && !is_io) ram[mem_addr[RAM_ADDR_BITS-1:0]] <= mem_wdata;
    if (push) fifo[wp_q] <= mem_wdata;
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: random and directed checks against a behavioural model
module tb_data_memory_responder;
  localparam logic [17:0] IO = 18'h3FF00;
  logic clock = 0;
  logic reset_n = 0;
  logic [17:0] addr = 0, wd_r = 0;
  logic we_r = 0, ready = 0;
  logic [17:0] mem_rdata, tx_data;
  logic wake, tx_valid;
  int pass_cnt = 0, total_cnt = 0;

  logic [17:0] m_rdata = 0, m_hi = 0;
  bit m_known = 1, m_wake = 0, m_ovf = 0;
  int m_timer = 0;
  longint m_cyc = 0;
  logic [17:0] m_q[$];
  logic [17:0] m_ram [1024];
  bit m_ramk [1024];

  data_memory_responder dut (
    .clock(clock), .reset_n(reset_n), .mem_addr(addr), .mem_write_enable(we_r),
    .mem_wdata(wd_r), .mem_rdata(mem_rdata), .wake(wake), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [17:0] got, input logic [17:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  task automatic step(input logic [17:0] a, input logic we, input logic [17:0] wd, input logic rdy);
    addr = a; we_r = we; wd_r = wd; ready = rdy;
    @(posedge clock); #2;
  endtask

  always @(posedge clock or negedge reset_n) begin
    bit io, pop, full, preq;
    int off, idx;
    logic [17:0] rd;
    if (!reset_n) begin
      m_rdata = 0; m_known = 1; m_wake = 0; m_q.delete(); m_cyc = 0; m_hi = 0; m_timer = 0; m_ovf = 0;
    end else begin
      io = addr >= IO;
      off = int'(addr) - int'(IO);
      idx = int'(addr) % 1024;
      if (we_r) begin
        rd = wd_r; m_known = 1;
      end else if (io) begin
        m_known = 1;
        case (off)
          0: rd = m_cyc[17:0];
          1: rd = m_hi;
          2: rd = 18'(m_timer);
          4: rd = 18'((m_q.size() << 3) + (int'(m_ovf) << 2) + ((m_q.size() == 4) ? 2 : 0) + ((m_q.size() == 0) ? 1 : 0));
          default: rd = 0;
        endcase
      end else begin
        rd = m_ram[idx]; m_known = m_ramk[idx];
      end
      if (we_r && io && off == 2) begin
        m_timer = int'(wd_r); m_wake = 0;
      end else if (m_timer > 0) begin
        m_timer--; m_wake = (m_timer == 0);
      end else m_wake = 0;
      if (!we_r && io && off == 0) m_hi = 18'(m_cyc >> 18);
      m_cyc = (m_cyc + 1) % (64'd1 << 36);
      full = m_q.size() == 4;
      pop = m_q.size() > 0 && ready;
      preq = we_r && io && off == 3;
      if (pop) void'(m_q.pop_front());
      if (preq) begin
        if (!full || pop) m_q.push_back(wd_r);
        else m_ovf = 1;
      end
      if (we_r && io && off == 4 && wd_r[2]) m_ovf = 0;
      if (we_r && !io) begin
        m_ram[idx] = wd_r; m_ramk[idx] = 1;
      end
      m_rdata = rd;
    end
  end

  always @(negedge clock) begin
    if (m_known) chk("rdata", mem_rdata, m_rdata);
    chk("wake", 18'(wake), 18'(m_wake));
    chk("tx_valid", 18'(tx_valid), 18'(m_q.size() != 0));
    if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
  end

  initial begin
    #12;
    chk("reset_rdata", mem_rdata, 18'h0);
    chk("reset_wake", 18'(wake), 18'h0);
    chk("reset_tx_valid", 18'(tx_valid), 18'h0);
    @(posedge clock); #2; reset_n = 1;
    for (int i = 0; i < 16; i++) step(18'(i), 1, 18'(i * 7 + 1), 0);
    step(18'd5, 1, 18'h12345, 0);
    step(18'd5, 0, 0, 0);
    chk("ram_read", mem_rdata, 18'h12345);
    step(18'd5 + 18'd1024, 0, 0, 0);
    chk("ram_alias", mem_rdata, 18'h12345);
    step(18'd7, 1, 18'h2AAAA, 0);
    step(18'd7, 0, 0, 0);
    chk("write_then_read", mem_rdata, 18'h2AAAA);
    step(IO + 18'd2, 1, 18'd3, 0);
    chk("timer_w0", 18'(wake), 18'h0);
    step(18'd0, 0, 0, 0); chk("timer_w1", 18'(wake), 18'h0);
    step(18'd0, 0, 0, 0); chk("timer_w2", 18'(wake), 18'h0);
    step(18'd0, 0, 0, 0); chk("timer_w3", 18'(wake), 18'h1);
    step(18'd0, 0, 0, 0); chk("timer_w4", 18'(wake), 18'h0);
    step(IO + 18'd2, 1, 18'd5, 0);
    step(18'd0, 0, 0, 0);
    step(IO + 18'd2, 1, 18'd0, 0);
    for (int i = 0; i < 8; i++) begin
      step(18'd0, 0, 0, 0);
      chk("timer_cancel", 18'(wake), 18'h0);
    end
    for (int i = 1; i <= 5; i++) step(IO + 18'd3, 1, 18'(i), 0);
    step(IO + 18'd4, 0, 0, 0);
    chk("status_overflow", mem_rdata, 18'h26);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_head", tx_data, 18'(i));
      step(18'd0, 0, 0, 1);
    end
    chk("drain_empty", 18'(tx_valid), 18'h0);
    step(IO + 18'd4, 1, 18'd4, 0);
    step(IO + 18'd4, 0, 0, 0);
    chk("status_cleared", mem_rdata, 18'h1);
    for (int i = 10; i <= 13; i++) step(IO + 18'd3, 1, 18'(i), 0);
    step(IO + 18'd3, 1, 18'd14, 1);
    step(IO + 18'd4, 0, 0, 0);
    chk("status_push_pop_full", mem_rdata, 18'h22);
    chk("head_after_pop", tx_data, 18'd11);
    for (int i = 0; i < 4; i++) step(18'd0, 0, 0, 1);
    step(IO + 18'd3, 1, 18'h111, 0);
    step(IO + 18'd3, 1, 18'h222, 0);
    step(IO + 18'd2, 1, 18'd10, 0);
    reset_n = 0;
    #1;
    chk("async_tx_valid", 18'(tx_valid), 18'h0);
    chk("async_wake", 18'(wake), 18'h0);
    chk("async_rdata", mem_rdata, 18'h0);
    @(posedge clock); #2; reset_n = 1;
    step(18'd5, 0, 0, 0);
    chk("ram_kept", mem_rdata, 18'h12345);
    for (int i = 0; i < 14; i++) step(18'd0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      logic [17:0] a, wd;
      logic we;
      logic [7:0] off;
      r = $urandom_range(0, 99);
      we = $urandom_range(0, 2) == 0;
      wd = 18'($urandom);
      if (r < 40) a = 18'(($urandom_range(0, 254) << 10) | $urandom_range(0, 15));
      else begin
        off = 8'($urandom_range(0, 6));
        if (off == 8'd6) off = 8'($urandom);
        a = IO + 18'(off);
        if (off == 8'd2) wd = 18'($urandom_range(0, 20));
        if (off == 8'd3) we = 1'($urandom_range(0, 1));
      end
      step(a, we, wd, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
